// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
//   Shared definitions for the UART transmit arbiter:
//   - arb_state_t : controller states IDLE / HDR / DATA
//   - HDR_BASE    : channel-ID header byte, OR-ed with the granted index
//   - wrap_add    : modular index addition used by the round-robin search
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  localparam logic [7:0] HDR_BASE = 8'hA0;

  // (a + b) mod n, valid for a < n, b < n, n <= 8
  function automatic logic [2:0] wrap_add(input logic [2:0] a,
                                          input logic [2:0] b,
                                          input int         n);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 4'(n)) begin
      s = s - 4'(n);
    end
    return s[2:0];
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker
//   Round-robin priority picker. Searches req upward starting at ptr,
//   wrapping from N-1 to 0, and returns the first requester found.
// Ports:
//   req [N-1:0] in  : request vector
//   ptr [2:0]   in  : index with highest priority (must be < N)
//   gnt [N-1:0] out : one-hot grant, zero when nothing requests
//   idx [2:0]   out : index of the granted requester (0 when none)
//   any         out : at least one requester present
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N = 4
)(
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [N-1:0] gnt,
  output logic [2:0]   idx,
  output logic         any
);

  logic [7:0]   req_ext;
  logic [2:0]   cand_idx [N];
  logic [N-1:0] cand_req;

  // Widened copy so a 3-bit index never falls outside the vector.
  assign req_ext = 8'(req);

  // Candidate gi is the requester examined at priority position gi.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    assign cand_idx[gi] = wrap_add(ptr, 3'(gi), N);
    assign cand_req[gi] = req_ext[cand_idx[gi]];
  end

  // Scan from lowest priority up so the highest-priority hit wins last.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        idx = cand_idx[k];
        any = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_gnt
    assign gnt[gi] = any && (idx == 3'(gi));
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Merges N byte streams onto one UART transmitter. A requester wins by
//   round-robin, optionally announced by a header byte (A0 | id), and may
//   then keep the grant for up to MAX_BURST data bytes while it stays valid.
// Parameters:
//   N         : number of requesters (2..8)
//   ADD_ID    : 1 = send header byte at the start of each burst
//   MAX_BURST : data bytes per burst (1..15)
// Ports:
//   clk, rst   : clock; asynchronous active-low reset
//   req_valid  : per-requester byte available
//   req_data   : requester i byte on [8i+7:8i]
//   req_ready  : per-requester accept (one-hot or zero, only in IDLE)
//   tx_valid / tx_data / tx_ready : byte stream to the UART transmitter
//   gnt_id     : current or last granted requester
//   busy       : controller not in IDLE
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int ADD_ID    = 1,
  parameter int MAX_BURST = 4
)(
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           tx_valid,
  output logic [7:0]     tx_data,
  input  logic           tx_ready,
  output logic [2:0]     gnt_id,
  output logic           busy
);

  arb_state_t state_reg;
  logic       tx_valid_reg;
  logic [7:0] tx_data_reg;
  logic [7:0] hold_reg;
  logic [2:0] gnt_id_reg;
  logic [2:0] ptr_reg;
  logic       burst_open_reg;
  logic [3:0] cnt_reg;

  logic [7:0]   valid_ext;
  logic [7:0]   data_arr [8];
  logic         idle;
  logic         continue_ok;
  logic         grant_any;
  logic [2:0]   rr_ptr;
  logic [2:0]   pick_idx;
  logic [2:0]   win_idx;
  logic         pick_any;
  logic [N-1:0] pick_gnt;

  assign valid_ext = 8'(req_valid);

  // Per-requester byte lanes, padded to 8 so the winner index selects directly.
  for (genvar gi = 0; gi < 8; gi++) begin : g_data
    if (gi < N) begin : g_used
      assign data_arr[gi] = req_data[8*gi +: 8];
    end else begin : g_unused
      assign data_arr[gi] = 8'h00;
    end
  end

  assign idle = (state_reg == ST_IDLE);

  // The locked requester keeps the grant while valid and under the byte limit.
  assign continue_ok = burst_open_reg && valid_ext[gnt_id_reg] &&
                       (cnt_reg < 4'(MAX_BURST));

  // When the open burst closes this cycle, arbitration already starts from
  // the slot after the locked requester.
  assign rr_ptr = burst_open_reg ? wrap_add(gnt_id_reg, 3'd1, N) : ptr_reg;

  rr_picker #(.N(N)) u_picker (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign win_idx   = continue_ok ? gnt_id_reg : pick_idx;
  assign grant_any = idle && (continue_ok || pick_any);

  // Gated by rst so the accept drops in the same cycle reset is asserted.
  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign req_ready[gi] = rst && idle &&
                           (continue_ok ? (gnt_id_reg == 3'(gi)) : pick_gnt[gi]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      tx_valid_reg   <= 1'b0;
      tx_data_reg    <= 8'h00;
      hold_reg       <= 8'h00;
      gnt_id_reg     <= 3'd0;
      ptr_reg        <= 3'd0;
      burst_open_reg <= 1'b0;
      cnt_reg        <= 4'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (burst_open_reg && !continue_ok) begin
            burst_open_reg <= 1'b0;
            cnt_reg        <= 4'd0;
            ptr_reg        <= rr_ptr;
          end
          if (grant_any) begin
            hold_reg     <= data_arr[win_idx];
            gnt_id_reg   <= win_idx;
            tx_valid_reg <= 1'b1;
            if (continue_ok) begin
              cnt_reg     <= cnt_reg + 4'd1;
              state_reg   <= ST_DATA;
              tx_data_reg <= data_arr[win_idx];
            end else begin
              burst_open_reg <= 1'b1;
              cnt_reg        <= 4'd1;
              if (ADD_ID != 0) begin
                state_reg   <= ST_HDR;
                tx_data_reg <= HDR_BASE | {5'b0, win_idx};
              end else begin
                state_reg   <= ST_DATA;
                tx_data_reg <= data_arr[win_idx];
              end
            end
          end
        end
        ST_HDR: begin
          // tx_valid stays high; only the byte changes to the held data.
          if (tx_ready) begin
            state_reg   <= ST_DATA;
            tx_data_reg <= hold_reg;
          end
        end
        ST_DATA: begin
          if (tx_ready) begin
            state_reg    <= ST_IDLE;
            tx_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg    <= ST_IDLE;
          tx_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign tx_valid = tx_valid_reg;
  assign tx_data  = tx_data_reg;
  assign gnt_id   = gnt_id_reg;
  assign busy     = !idle;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        tx_ready;

  // a: ADD_ID=1 MAX_BURST=4, b: ADD_ID=1 MAX_BURST=1, c: ADD_ID=0 MAX_BURST=4
  logic [3:0] rr_a, rr_b, rr_c;
  logic       tv_a, tv_b, tv_c;
  logic [7:0] td_a, td_b, td_c;
  logic [2:0] gid_a, gid_b, gid_c;
  logic       bz_a, bz_b, bz_c;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(4), .ADD_ID(1), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rr_a), .tx_valid(tv_a), .tx_data(td_a), .tx_ready(tx_ready),
    .gnt_id(gid_a), .busy(bz_a));

  uart_tx_arbiter #(.N(4), .ADD_ID(1), .MAX_BURST(1)) dut_mb1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rr_b), .tx_valid(tv_b), .tx_data(td_b), .tx_ready(tx_ready),
    .gnt_id(gid_b), .busy(bz_b));

  uart_tx_arbiter #(.N(4), .ADD_ID(0), .MAX_BURST(4)) dut_noid (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rr_c), .tx_valid(tv_c), .tx_data(td_c), .tx_ready(tx_ready),
    .gnt_id(gid_c), .busy(bz_c));

  int vectors = 0;
  int miscompares = 0;

  // Requester byte sources: each holds its head byte valid until accepted.
  logic [7:0] qmem [4][16];
  int         qhead [4];
  int         qlen [4];

  logic [7:0] got [$];
  int         gnt_order [$];
  int         ready_cycles [4];
  int         onehot_err;
  int         stall_err;

  // Reference model state (transaction level)
  logic [7:0] exp_q [$];
  int         m_ptr, m_lock, m_cnt;
  bit         m_open;

  task automatic drive_inputs();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = (qhead[i] < qlen[i]);
      req_data[8*i +: 8] = (qhead[i] < qlen[i]) ? qmem[i][qhead[i]] : 8'h00;
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < 4; i++) begin
      qhead[i] = 0;
      qlen[i]  = 0;
    end
  endtask

  task automatic push(input int i, input logic [7:0] b);
    qmem[i][qlen[i]] = b;
    qlen[i]++;
  endtask

  task automatic clear_stats();
    got.delete();
    gnt_order.delete();
    for (int i = 0; i < 4; i++) ready_cycles[i] = 0;
    onehot_err = 0;
    stall_err  = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tx_ready = 1'b0;
    clear_queues();
    drive_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Runs n cycles observing instance sel; acts as the requesters and the UART.
  task automatic run_cycles(input int n, input int sel, input int pct);
    logic [3:0] o_rr;
    logic       o_tv;
    logic [7:0] o_td;
    logic       prev_stall;
    logic [7:0] prev_td;
    int         up;
    prev_stall = 1'b0;
    prev_td    = 8'h00;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      case (sel)
        0:       begin o_rr = rr_a; o_tv = tv_a; o_td = td_a; end
        1:       begin o_rr = rr_b; o_tv = tv_b; o_td = td_b; end
        default: begin o_rr = rr_c; o_tv = tv_c; o_td = td_c; end
      endcase
      if (prev_stall && (!o_tv || o_td !== prev_td)) stall_err++;
      prev_stall = o_tv && !tx_ready;
      prev_td    = o_td;
      if ($countones(o_rr) > 1 || (o_rr & ~req_valid) != 4'b0) onehot_err++;
      up = -1;
      for (int i = 0; i < 4; i++) begin
        if (o_rr[i]) begin
          ready_cycles[i]++;
          if (req_valid[i] && up < 0) up = i;
        end
      end
      if (o_tv && tx_ready) begin
        got.push_back(o_td);
        $display("[%0t] inst%0d tx byte 0x%02h", $time, sel, o_td);
      end
      if (up >= 0) gnt_order.push_back(up);
      @(posedge clk);
      #1;
      if (up >= 0) qhead[up]++;
      drive_inputs();
      tx_ready = (int'($urandom_range(99)) < pct);
    end
  endtask

  // Expected downstream byte stream from the queued bytes, max_burst bytes per lock.
  task automatic model_predict(input int max_burst);
    int  mh [4];
    bit  done;
    bit  found;
    int  i;
    exp_q.delete();
    for (int k = 0; k < 4; k++) mh[k] = qhead[k];
    done = 0;
    while (!done) begin
      if (m_open && mh[m_lock] < qlen[m_lock] && m_cnt < max_burst) begin
        exp_q.push_back(qmem[m_lock][mh[m_lock]]);
        mh[m_lock]++;
        m_cnt++;
      end else begin
        if (m_open) begin
          m_ptr  = (m_lock + 1) % 4;
          m_open = 0;
          m_cnt  = 0;
        end
        found = 0;
        for (int k = 0; k < 4; k++) begin
          i = (m_ptr + k) % 4;
          if (!found && mh[i] < qlen[i]) begin
            found = 1;
            exp_q.push_back(8'hA0 | 8'(i));
            exp_q.push_back(qmem[i][mh[i]]);
            mh[i]++;
            m_lock = i;
            m_open = 1;
            m_cnt  = 1;
          end
        end
        if (!found) done = 1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_queues();
    for (int i = 0; i < 4; i++) push(i, 8'(8'h10 + i));
    drive_inputs();
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (tv_a !== 1'b0 || td_a !== 8'h00 || rr_a !== 4'b0 || gid_a !== 3'd0 || bz_a !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: tv=%b td=%02h rr=%b gid=%0d busy=%b, want 0 00 0000 0 0",
               tv_a, td_a, rr_a, gid_a, bz_a);
    end
    vectors++;
    if (rr_b !== 4'b0 || rr_c !== 4'b0 || tv_b !== 1'b0 || tv_c !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_other_inst: rr_b=%b rr_c=%b tv_b=%b tv_c=%b, want all 0",
               rr_b, rr_c, tv_b, tv_c);
    end
  endtask

  task automatic test_single();
    logic [7:0] e [2] = '{8'hA0, 8'h55};
    rst = 1'b0;
    clear_queues();
    push(0, 8'h55);
    drive_inputs();
    tx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (rr_a !== 4'b0001) begin
      miscompares++;
      $display("FAIL single_ready_after_reset: got %b want 0001", rr_a);
    end
    @(posedge clk);
    #1;
    qhead[0]++;
    drive_inputs();
    vectors++;
    if (tv_a !== 1'b1 || td_a !== 8'hA0 || gid_a !== 3'd0 || bz_a !== 1'b1) begin
      miscompares++;
      $display("FAIL single_latency: tv=%b td=%02h gid=%0d busy=%b want 1 a0 0 1",
               tv_a, td_a, gid_a, bz_a);
    end
    clear_stats();
    run_cycles(8, 0, 100);
    vectors++;
    if (got.size() != 2) begin
      miscompares++;
      $display("FAIL single_count: got %0d bytes want 2", got.size());
    end
    for (int j = 0; j < 2 && j < got.size(); j++) begin
      vectors++;
      if (got[j] !== e[j]) begin
        miscompares++;
        $display("FAIL single_byte%0d: got %02h want %02h", j, got[j], e[j]);
      end
    end
    vectors++;
    if (ready_cycles[0] != 0) begin
      miscompares++;
      $display("FAIL single_ready_once: extra ready cycles %0d want 0", ready_cycles[0]);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] e [10] = '{8'hA0, 8'h10, 8'hA1, 8'h11, 8'hA2, 8'h12, 8'hA3, 8'h13, 8'hA0, 8'h14};
    int         g [5]  = '{0, 1, 2, 3, 0};
    do_reset();
    push(0, 8'h10); push(0, 8'h14);
    push(1, 8'h11); push(2, 8'h12); push(3, 8'h13);
    drive_inputs();
    tx_ready = 1'b1;
    clear_stats();
    run_cycles(40, 1, 100);
    vectors++;
    if (got.size() != 10 || gnt_order.size() != 5) begin
      miscompares++;
      $display("FAIL rr_count: bytes %0d grants %0d want 10 5", got.size(), gnt_order.size());
    end
    for (int j = 0; j < 10 && j < got.size(); j++) begin
      vectors++;
      if (got[j] !== e[j]) begin
        miscompares++;
        $display("FAIL rr_byte%0d: got %02h want %02h", j, got[j], e[j]);
      end
    end
    for (int j = 0; j < 5 && j < gnt_order.size(); j++) begin
      vectors++;
      if (gnt_order[j] != g[j]) begin
        miscompares++;
        $display("FAIL rr_grant%0d: got %0d want %0d", j, gnt_order[j], g[j]);
      end
    end
  endtask

  task automatic test_burst_lock();
    logic [7:0] e [10] = '{8'hA2, 8'h20, 8'h21, 8'h22, 8'h23, 8'hA3, 8'h30, 8'hA2, 8'h24, 8'h25};
    do_reset();
    for (int k = 0; k < 6; k++) push(2, 8'(8'h20 + k));
    push(3, 8'h30);
    drive_inputs();
    tx_ready = 1'b1;
    clear_stats();
    run_cycles(60, 0, 100);
    vectors++;
    if (got.size() != 10) begin
      miscompares++;
      $display("FAIL burst_count: got %0d bytes want 10", got.size());
    end
    for (int j = 0; j < 10 && j < got.size(); j++) begin
      vectors++;
      if (got[j] !== e[j]) begin
        miscompares++;
        $display("FAIL burst_byte%0d: got %02h want %02h", j, got[j], e[j]);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] e [4] = '{8'hA1, 8'h5A, 8'hA3, 8'h11};
    do_reset();
    push(1, 8'h5A);
    push(3, 8'h11);
    drive_inputs();
    tx_ready = 1'b0;
    run_cycles(1, 0, 0);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      vectors++;
      if (tv_a !== 1'b1 || td_a !== 8'hA1 || rr_a !== 4'b0 || bz_a !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_cycle%0d: tv=%b td=%02h rr=%b busy=%b want 1 a1 0000 1",
                 c, tv_a, td_a, rr_a, bz_a);
      end
    end
    clear_stats();
    run_cycles(30, 0, 100);
    vectors++;
    if (got.size() != 4) begin
      miscompares++;
      $display("FAIL stall_count: got %0d bytes want 4", got.size());
    end
    for (int j = 0; j < 4 && j < got.size(); j++) begin
      vectors++;
      if (got[j] !== e[j]) begin
        miscompares++;
        $display("FAIL stall_byte%0d: got %02h want %02h", j, got[j], e[j]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(2, 8'h77);
    drive_inputs();
    tx_ready = 1'b0;
    run_cycles(1, 0, 0);
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    vectors++;
    if (tv_a !== 1'b1 || td_a !== 8'h77 || gid_a !== 3'd2) begin
      miscompares++;
      $display("FAIL midrst_in_data: tv=%b td=%02h gid=%0d want 1 77 2", tv_a, td_a, gid_a);
    end
    #3;
    rst = 1'b0;
    #1;
    vectors++;
    if (tv_a !== 1'b0 || td_a !== 8'h00 || rr_a !== 4'b0 || gid_a !== 3'd0 || bz_a !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_outputs: tv=%b td=%02h rr=%b gid=%0d busy=%b want 0 00 0000 0 0",
               tv_a, td_a, rr_a, gid_a, bz_a);
    end
    @(negedge clk);
    rst = 1'b1;
    tx_ready = 1'b1;
    clear_stats();
    run_cycles(20, 0, 100);
    vectors++;
    if (got.size() != 0) begin
      miscompares++;
      $display("FAIL midrst_no_replay: got %0d bytes want 0", got.size());
    end
  endtask

  task automatic test_no_id();
    do_reset();
    push(1, 8'h3C);
    drive_inputs();
    tx_ready = 1'b1;
    clear_stats();
    run_cycles(10, 2, 100);
    vectors++;
    if (got.size() != 1) begin
      miscompares++;
      $display("FAIL noid_count: got %0d bytes want 1", got.size());
    end
    if (got.size() > 0) begin
      vectors++;
      if (got[0] !== 8'h3C) begin
        miscompares++;
        $display("FAIL noid_byte: got %02h want 3c", got[0]);
      end
    end
  endtask

  task automatic test_random();
    int total;
    do_reset();
    m_ptr = 0; m_lock = 0; m_cnt = 0; m_open = 0;
    for (int r = 0; r < 6; r++) begin
      clear_queues();
      total = 0;
      for (int i = 0; i < 4; i++) begin
        int len;
        len = int'($urandom_range(0, 7));
        for (int k = 0; k < len; k++) push(i, 8'($urandom));
        total += len;
      end
      model_predict(4);
      drive_inputs();
      clear_stats();
      run_cycles(40 + 10 * total, 0, 70);
      vectors++;
      if (got.size() != exp_q.size()) begin
        miscompares++;
        $display("FAIL rand%0d_count: got %0d bytes want %0d", r, got.size(), exp_q.size());
      end
      for (int j = 0; j < exp_q.size() && j < got.size(); j++) begin
        vectors++;
        if (got[j] !== exp_q[j]) begin
          miscompares++;
          $display("FAIL rand%0d_byte%0d: got %02h want %02h", r, j, got[j], exp_q[j]);
        end
      end
      vectors++;
      if (onehot_err != 0 || stall_err != 0) begin
        miscompares++;
        $display("FAIL rand%0d_protocol: ready violations %0d stall violations %0d want 0 0",
                 r, onehot_err, stall_err);
      end
    end
  endtask

  initial begin
    req_valid = '0;
    req_data  = '0;
    tx_ready  = 1'b0;
    clear_queues();
    clear_stats();
    test_reset();
    test_single();
    test_round_robin();
    test_burst_lock();
    test_stall();
    test_reset_mid();
    test_no_id();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter ADD_ID, default 1, meaning 1 = send a channel-ID header byte before each granted burst.
REQ-003 SHALL have parameter MAX_BURST, default 4, meaning max data bytes per grant (1..15).
REQ-004 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  N  per-requester byte-available.
REQ-007 SHALL have port req_data  input  8*N  requester i byte on bits [8i+7:8i].
REQ-008 SHALL have port req_ready  output  N  per-requester accept, one-hot or zero.
REQ-009 SHALL have port tx_valid  output  1  byte offered to the UART transmitter.
REQ-010 SHALL have port tx_data  output  8  byte to the UART transmitter.
REQ-011 SHALL have port tx_ready  input  1  UART transmitter can accept.
REQ-012 SHALL have port gnt_id  output  3  index of the current or last granted requester.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL define upstream transfer as req_valid[i] && req_ready[i] at a clk edge, and downstream transfer as tx_valid && tx_ready at a clk edge.
REQ-015 SHALL use states IDLE, HDR and DATA; HDR is skipped when ADD_ID=0 or the grant continues a burst.
REQ-016 SHALL, in IDLE, drive req_ready combinationally one-hot to the winner; req_ready is zero in HDR and DATA.
REQ-017 SHALL select the winner round-robin, searching from ptr upward with wrap from N-1 to 0, except where REQ-022 applies.
REQ-018 SHALL, on upstream transfer, capture req_data[i] into a hold register and set gnt_id=i; ptr becomes (i+1) mod N when the burst ends.
REQ-019 SHALL, on a new burst, go IDLE->HDR, else IDLE->DATA; tx_valid SHALL rise in the cycle after the upstream transfer (1-cycle latency).
REQ-020 SHALL drive tx_data = 8'hA0 | gnt_id in HDR and the hold byte in DATA, holding tx_valid and tx_data stable until downstream transfer.
REQ-021 SHALL go HDR->DATA on downstream transfer, and DATA->IDLE on downstream transfer; tx_valid SHALL stay high across the HDR->DATA edge.
REQ-022 SHALL, in IDLE with a burst open, grant only the locked requester if it is valid and fewer than MAX_BURST bytes have been sent; otherwise the burst closes and normal round-robin arbitration proceeds in the same cycle.
REQ-023 SHALL count burst bytes 0..MAX_BURST in a 4-bit counter that clears when the burst closes.
REQ-024 SHALL hold state indefinitely while tx_ready is low, with no timeout.
REQ-025 SHALL treat req_valid deasserted before grant as no request, with no transfer and no error.
REQ-026 SHALL ignore req_data changes after capture.

Reset
REQ-027 SHALL, while rst is low, force: state IDLE, tx_valid 0, tx_data 8'h00, req_ready 0, gnt_id 0, busy 0, ptr 0, burst closed, counter 0.
REQ-028 SHALL abandon an in-flight header or data byte on reset assertion mid-operation, with no replay after release.
REQ-029 SHALL allow the first grant on the first clk edge after rst rises.

Structure
REQ-030 SHALL place the state encoding (IDLE/HDR/DATA) and the header constant 8'hA0 in shared package uart_arb_pkg.
REQ-031 SHALL implement the round-robin priority picker (req vector, ptr -> one-hot grant plus index) as sub-module rr_picker.

Verification
REQ-032 SHALL cover single requester, N=4, ADD_ID=1, tx_ready=1: req_valid=0001, data 8'h55 -> tx sequence A0, 55; req_ready[0] high exactly 1 cycle.
REQ-033 SHALL cover all four valid with ptr=0, MAX_BURST=1 -> grant order 0,1,2,3,0; headers A0,A1,A2,A3,A0.
REQ-034 SHALL cover requester 2 continuously valid, MAX_BURST=4 -> A2 then 4 data bytes, then the burst closes; requester 3 valid is granted next.
REQ-035 SHALL cover tx_ready held low 50 cycles in HDR -> tx_valid=1 and tx_data=A1 stable for all 50 cycles; no req_ready.
REQ-036 SHALL cover rst low in DATA -> all outputs at reset values in the same cycle; the byte is never sent after release.
REQ-037 SHALL cover ADD_ID=0 with requester 1, data 8'h3C -> single tx byte 3C with no header.
